uart_program_loader: RTL

- Boot-time loader upstream of the RISC-V core and its instruction/data memory inside the virtual device.
- Receives a framed program image over the UART RX line at 8N1 and writes it word by word into memory.
- Holds the CPU in reset until the image is loaded and its checksum matches.
- Produces the `loading_complete` flag the device exposes at top level.

---
 rtl/uart_program_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: deserializes an 8N1 UART stream carrying a framed, XOR-checksummed
// program image, writes it word by word into memory, then releases the CPU reset.
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 4096,
  parameter logic [7:0]  MAGIC        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        cpu_rst,
  output logic        loading_complete,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {L_WAIT_MAGIC, L_LEN, L_DATA, L_WRITE, L_CSUM, L_DONE, L_ERROR} ld_state_e;

  logic        sync1_q, sync2_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        byte_valid, frame_err;

  ld_state_e   ld_q, ld_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) rx_state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        // A start bit that has gone high again by mid-bit is line noise
        cnt_d      = '0;
        bit_d      = '0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shreg_d = {sync2_q, shreg_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
        byte_valid = sync2_q;
        frame_err  = !sync2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_d    = ld_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    word_d  = word_q;
    csum_d  = csum_q;
    words_d = words_q;
    addr_d  = addr_q;
    case (ld_q)
      L_WAIT_MAGIC: begin
        csum_d = '0;
        bcnt_d = '0;
        if (byte_valid && shreg_q == MAGIC) ld_d = L_LEN;
      end
      L_LEN: if (byte_valid) begin
        csum_d = csum_q ^ shreg_q;
        len_d  = {shreg_q, len_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          if (len_d > 32'(MAX_WORDS)) ld_d = L_ERROR;
          else if (len_d == '0)       ld_d = L_CSUM;
          else                        ld_d = L_DATA;
        end
      end
      L_DATA: if (byte_valid) begin
        csum_d = csum_q ^ shreg_q;
        word_d = {shreg_q, word_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) ld_d = L_WRITE;
      end
      L_WRITE: begin
        if (mem_ready) begin
          if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
          addr_d = addr_q + 32'd4;
          ld_d   = (32'(words_q) + 32'd1 == len_q) ? L_CSUM : L_DATA;
        end
        // A byte landing before the write retires means the sender outran memory
        if (byte_valid) ld_d = L_ERROR;
      end
      L_CSUM: if (byte_valid) ld_d = (shreg_q == csum_q) ? L_DONE : L_ERROR;
      default: ;
    endcase
    if (frame_err && ld_q != L_DONE) ld_d = L_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      ld_q       <= L_WAIT_MAGIC;
      bcnt_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      ld_q       <= ld_d;
      bcnt_q     <= bcnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_we           = (ld_q == L_WRITE);
  assign mem_addr         = addr_q;
  assign mem_wdata        = word_q;
  assign cpu_rst          = (ld_q != L_DONE);
  assign loading_complete = (ld_q == L_DONE);
  assign load_error       = (ld_q == L_ERROR);
  assign words_loaded     = words_q;
endmodule
